// File: rtl/tmds_link_generator.sv
// rtl/tmds_link_generator.sv - parallel TMDS symbol generator with optional HDMI preamble/guard-band insertion
module tmds_link_generator #(
    parameter int CHANNELS = 3,
    parameter int HDMI_GB  = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_de,
    input  logic [8*CHANNELS-1:0]  i_data,
    input  logic [2*CHANNELS-1:0]  i_ctrl,
    output logic                   o_de,
    output logic [10*CHANNELS-1:0] o_tmds,
    output logic [9:0]             o_tmds_clk
);

    localparam logic [9:0] CTL_00 = 10'b1101010100;
    localparam logic [9:0] CTL_01 = 10'b0010101011;
    localparam logic [9:0] CTL_10 = 10'b0101010100;
    localparam logic [9:0] CTL_11 = 10'b1010101011;
    localparam logic [9:0] GB_02  = 10'b1011001100;
    localparam logic [9:0] GB_1   = 10'b0100110011;

    logic                  dl_de;
    logic [8*CHANNELS-1:0] dl_data;
    logic [2*CHANNELS-1:0] dl_ctrl;
    logic                  near_guard;
    logic                  near_pre;

    generate
        if (HDMI_GB != 0) begin : g_delay
            logic [9:0]            de_q, de_d;
            logic [8*CHANNELS-1:0] data_q [10];
            logic [8*CHANNELS-1:0] data_d [10];
            logic [2*CHANNELS-1:0] ctrl_q [10];
            logic [2*CHANNELS-1:0] ctrl_d [10];
            // ahead[j-1] is the de of the sample j cycles after the one leaving the line
            logic [9:0]            ahead;

            always_comb begin
                de_d      = {de_q[8:0], i_de};
                data_d[0] = i_data;
                ctrl_d[0] = i_ctrl;
                for (int k = 1; k < 10; k++) begin
                    data_d[k] = data_q[k-1];
                    ctrl_d[k] = ctrl_q[k-1];
                end
                ahead = '0;
                for (int j = 1; j < 10; j++) begin
                    ahead[j-1] = de_q[9-j];
                end
                ahead[9] = i_de;
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    de_q <= '0;
                    for (int k = 0; k < 10; k++) begin
                        data_q[k] <= '0;
                        ctrl_q[k] <= '0;
                    end
                end else begin
                    de_q   <= de_d;
                    data_q <= data_d;
                    ctrl_q <= ctrl_d;
                end
            end

            assign dl_de      = de_q[9];
            assign dl_data    = data_q[9];
            assign dl_ctrl    = ctrl_q[9];
            assign near_guard = |ahead[1:0];
            assign near_pre   = ~near_guard & (|ahead[9:2]);
        end else begin : g_direct
            assign dl_de      = i_de;
            assign dl_data    = i_data;
            assign dl_ctrl    = i_ctrl;
            assign near_guard = 1'b0;
            assign near_pre   = 1'b0;
        end
    endgenerate

    function automatic logic [8:0] minimise(input logic [7:0] d);
        logic [3:0] ones;
        logic       use_xnor;
        logic [8:0] q;
        ones     = 4'($countones(d));
        use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    // Returns {next_cnt, symbol}; 5-bit wraparound is exact while |cnt| stays within 8.
    function automatic logic [14:0] balance(input logic [8:0] qm, input logic signed [4:0] cnt);
        logic [3:0]        n1;
        logic signed [4:0] diff;
        logic signed [4:0] two_q8;
        logic signed [4:0] nxt;
        logic [9:0]        sym;
        n1     = 4'($countones(qm[7:0]));
        diff   = $signed({n1, 1'b0} - 5'd8);
        two_q8 = qm[8] ? 5'sd2 : 5'sd0;
        if ((cnt == 5'sd0) || (n1 == 4'd4)) begin
            sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            nxt = qm[8] ? (cnt + diff) : (cnt - diff);
        end else if (((cnt > 5'sd0) && (n1 > 4'd4)) || ((cnt < 5'sd0) && (n1 < 4'd4))) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            nxt = cnt + two_q8 - diff;
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            nxt = cnt - (5'sd2 - two_q8) + diff;
        end
        return {nxt, sym};
    endfunction

    function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
        case (c)
            2'b00:   return CTL_00;
            2'b01:   return CTL_01;
            2'b10:   return CTL_10;
            default: return CTL_11;
        endcase
    endfunction

    logic                       s1_de_q, s1_de_d;
    logic                       s1_guard_q, s1_guard_d;
    logic [CHANNELS-1:0][8:0]   s1_qm_q, s1_qm_d;
    logic [CHANNELS-1:0][1:0]   s1_ctrl_q, s1_ctrl_d;

    // Preamble rewrites the control code of roles 1 and 2; role 0 keeps sync.
    always_comb begin
        s1_de_d    = dl_de;
        s1_guard_d = ~dl_de & near_guard;
        s1_qm_d    = '0;
        s1_ctrl_d  = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            s1_qm_d[n]   = minimise(dl_data[8*n +: 8]);
            s1_ctrl_d[n] = dl_ctrl[2*n +: 2];
            if (!dl_de && near_pre) begin
                if ((n % 3) == 1) begin
                    s1_ctrl_d[n] = 2'b01;
                end else if ((n % 3) == 2) begin
                    s1_ctrl_d[n] = 2'b00;
                end
            end
        end
    end

    logic                   de_q, de_d;
    logic [10*CHANNELS-1:0] tmds_q, tmds_d;
    logic signed [4:0]      cnt_q [CHANNELS];
    logic signed [4:0]      cnt_d [CHANNELS];

    always_comb begin
        de_d   = s1_de_q;
        tmds_d = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            cnt_d[n] = '0;
            if (s1_de_q) begin
                {cnt_d[n], tmds_d[10*n +: 10]} = balance(s1_qm_q[n], cnt_q[n]);
            end else if (s1_guard_q) begin
                tmds_d[10*n +: 10] = ((n % 3) == 1) ? GB_1 : GB_02;
            end else begin
                tmds_d[10*n +: 10] = ctrl_symbol(s1_ctrl_q[n]);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_de_q    <= 1'b0;
            s1_guard_q <= 1'b0;
            s1_qm_q    <= '0;
            s1_ctrl_q  <= '0;
            de_q       <= 1'b0;
            tmds_q     <= {CHANNELS{CTL_00}};
            for (int n = 0; n < CHANNELS; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            s1_de_q    <= s1_de_d;
            s1_guard_q <= s1_guard_d;
            s1_qm_q    <= s1_qm_d;
            s1_ctrl_q  <= s1_ctrl_d;
            de_q       <= de_d;
            tmds_q     <= tmds_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_de       = de_q;
    assign o_tmds     = tmds_q;
    assign o_tmds_clk = 10'b0000011111;

endmodule
